// File: rtl/cache_fill_if.sv
// cache_fill_if: miss/memory/cache-array handshake bundle for the block fill FSM
interface cache_fill_if;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic        fsm_busy;
   logic        write_data_array;
   logic [2:0]  word_num;
   logic        write_tag_array;
   modport master (
      input  miss_detected, miss_address, memory_data_valid,
      output mem_read_en, memory_address, fsm_busy, write_data_array, word_num, write_tag_array
   );
   modport slave (
      output miss_detected, miss_address, memory_data_valid,
      input  mem_read_en, memory_address, fsm_busy, write_data_array, word_num, write_tag_array
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches an 8-word block after a miss, overlapping request issue with data return
module cache_fill_fsm (
   input logic         clk,
   input logic         rst,
   cache_fill_if.master bus
);
   typedef enum logic {IDLE, FILL} state_t;
   state_t      state_q, state_d;
   logic [11:0] base_q, base_d;
   logic [3:0]  issue_q, issue_d, recv_q, recv_d;
   logic        fill, start, rd, wr, tag;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         issue_q <= '0;
         recv_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
      end
   end
   always_comb begin
      fill    = state_q == FILL;
      start   = !fill && bus.miss_detected;
      rd      = fill && !issue_q[3];
      wr      = fill && bus.memory_data_valid;
      tag     = wr && recv_q == 4'd7;
      state_d = start ? FILL : (tag ? IDLE : state_q);
      base_d  = start ? bus.miss_address[15:4] : base_q;
      issue_d = start ? 4'd0 : issue_q + {3'd0, rd};
      recv_d  = start ? 4'd0 : recv_q + {3'd0, wr};
   end
   always_comb begin
      bus.mem_read_en      = rd;
      bus.memory_address   = rd ? {base_q, issue_q[2:0], 1'b0} : 16'h0000;
      bus.fsm_busy         = fill;
      bus.write_data_array = wr;
      bus.word_num         = fill ? recv_q[2:0] : 3'b000;
      bus.write_tag_array  = tag;
   end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills checked each cycle against a count-based block-fill model
module tb_cache_fill_fsm;
   logic clk = 0, rst = 0;
   cache_fill_if bus();
   cache_fill_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   int cyc = 0;
   bit chk_en = 0;
   bit m_fill = 0;
   int m_base = 0, m_issued = 0, m_got = 0;
   logic        a_miss[64], a_valid[64], a_rst[64];
   logic [15:0] a_addr[64];
   logic        l_rd[64], l_wr[64], l_tag[64], l_busy[64];
   logic [15:0] l_addr[64];
   logic [2:0]  l_word[64];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask
   // model: a fill is just a base plus how many requests went out and how many words came back
   always @(posedge clk) begin
      if (!rst) begin
         m_fill <= 0; m_base <= 0; m_issued <= 0; m_got <= 0;
      end else if (!m_fill) begin
         if (bus.miss_detected) begin
            m_fill <= 1; m_base <= int'(bus.miss_address) / 16 * 16; m_issued <= 0; m_got <= 0;
         end
      end else begin
         if (m_issued < 8) m_issued <= m_issued + 1;
         if (bus.memory_data_valid) begin
            m_got <= m_got + 1;
            if (m_got == 7) m_fill <= 0;
         end
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         automatic bit rd = m_fill && m_issued < 8;
         automatic bit wr = m_fill && bus.memory_data_valid;
         check("busy", bus.fsm_busy, m_fill);
         check("rd", bus.mem_read_en, rd);
         check("addr", bus.memory_address, rd ? m_base + 2 * m_issued : 0);
         check("wr", bus.write_data_array, wr);
         check("word", bus.word_num, m_fill ? m_got : 0);
         check("tag", bus.write_tag_array, wr && m_got == 7);
         if (cyc < 64) begin
            l_rd[cyc] = bus.mem_read_en; l_wr[cyc] = bus.write_data_array; l_tag[cyc] = bus.write_tag_array;
            l_busy[cyc] = bus.fsm_busy; l_addr[cyc] = bus.memory_address; l_word[cyc] = bus.word_num;
         end
      end
   end
   task automatic clr();
      for (int i = 0; i < 64; i++) begin
         a_miss[i] = 0; a_valid[i] = 0; a_rst[i] = 1; a_addr[i] = 16'h0000;
         l_rd[i] = 0; l_wr[i] = 0; l_tag[i] = 0; l_busy[i] = 0; l_addr[i] = 0; l_word[i] = 0;
      end
   endtask
   task automatic play(input int n);
      for (int c = 0; c < n; c++) begin
         cyc = c;
         rst = a_rst[c];
         bus.miss_detected = a_miss[c];
         bus.miss_address = a_addr[c];
         bus.memory_data_valid = a_valid[c];
         @(posedge clk); #1;
      end
   endtask
   function automatic int count(input string what, input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++)
         n += (what == "wr") ? int'(l_wr[i]) : (what == "rd") ? int'(l_rd[i]) : (what == "tag") ? int'(l_tag[i]) : int'(l_busy[i]);
      return n;
   endfunction
   initial begin
      rst = 0; bus.miss_detected = 1; bus.miss_address = 16'hFFFF; bus.memory_data_valid = 1;
      @(posedge clk); #1;
      chk_en = 1;
      cyc = 0;
      check("rst_busy", bus.fsm_busy, 0);
      check("rst_rd", bus.mem_read_en, 0);
      check("rst_addr", bus.memory_address, 16'h0000);
      check("rst_wr", bus.write_data_array, 0);
      check("rst_tag", bus.write_tag_array, 0);
      clr(); a_rst[0] = 0; play(2);
      // basic fill, latency 4
      clr(); a_miss[0] = 1; a_addr[0] = 16'h3A56;
      for (int c = 5; c <= 12; c++) a_valid[c] = 1;
      play(16);
      check("b_addr1", l_addr[1], 16'h3A50);
      check("b_addr2", l_addr[2], 16'h3A52);
      check("b_addr8", l_addr[8], 16'h3A5E);
      check("b_rd9", l_rd[9], 0);
      check("b_rdcnt", count("rd", 0, 15), 8);
      check("b_word5", l_word[5], 0);
      check("b_word12", l_word[12], 7);
      check("b_tag12", l_tag[12], 1);
      check("b_tagcnt", count("tag", 0, 15), 1);
      check("b_busycnt", count("busy", 0, 15), 12);
      check("b_busy13", l_busy[13], 0);
      // latency 1
      clr(); a_miss[0] = 1; a_addr[0] = 16'h0008;
      for (int c = 2; c <= 9; c++) a_valid[c] = 1;
      play(13);
      check("l1_addr1", l_addr[1], 16'h0000);
      check("l1_addr8", l_addr[8], 16'h000E);
      check("l1_rdcnt", count("rd", 0, 12), 8);
      check("l1_wrcnt", count("wr", 0, 12), 8);
      check("l1_word9", l_word[9], 7);
      check("l1_tag9", l_tag[9], 1);
      check("l1_busy10", l_busy[10], 0);
      // gappy returns
      clr(); a_miss[0] = 1; a_addr[0] = 16'hBEEF;
      for (int c = 5; c <= 19; c += 2) a_valid[c] = 1;
      play(23);
      check("g_addr1", l_addr[1], 16'hBEE0);
      check("g_word7", l_word[7], 1);
      check("g_word8", l_word[8], 2);
      check("g_wrcnt", count("wr", 0, 22), 8);
      check("g_tag19", l_tag[19], 1);
      check("g_tag17", l_tag[17], 0);
      check("g_busycnt", count("busy", 1, 19), 19);
      check("g_busy20", l_busy[20], 0);
      // miss held during fill with a moving address
      clr();
      for (int c = 0; c <= 13; c++) begin a_miss[c] = 1; a_addr[c] = 16'h1234 + 16'(c) * 16'h0100; end
      for (int c = 5; c <= 12; c++) a_valid[c] = 1;
      for (int c = 18; c <= 25; c++) a_valid[c] = 1;
      play(29);
      check("m_addr1", l_addr[1], 16'h1230);
      check("m_addr8", l_addr[8], 16'h123E);
      check("m_tag12", l_tag[12], 1);
      check("m_busy13", l_busy[13], 0);
      check("m_addr14", l_addr[14], 16'h1F30);
      check("m_addr21", l_addr[21], 16'h1F3E);
      check("m_tag25", l_tag[25], 1);
      // reset mid-fill, then a clean fill
      clr(); a_miss[0] = 1; a_addr[0] = 16'h3A56; a_rst[6] = 0;
      for (int c = 5; c <= 12; c++) a_valid[c] = 1;
      a_miss[16] = 1; a_addr[16] = 16'h0040;
      for (int c = 21; c <= 28; c++) a_valid[c] = 1;
      play(32);
      check("r_busy6", l_busy[6], 1);
      check("r_busycnt", count("busy", 7, 16), 0);
      check("r_wrcnt", count("wr", 7, 16), 0);
      check("r_tagcnt", count("tag", 0, 16), 0);
      check("r_addr17", l_addr[17], 16'h0040);
      check("r_word21", l_word[21], 0);
      check("r_wr21", l_wr[21], 1);
      check("r_tag28", l_tag[28], 1);
      // stray data in idle
      clr(); for (int c = 1; c <= 3; c++) a_valid[c] = 1;
      play(6);
      check("s_wrcnt", count("wr", 0, 5), 0);
      check("s_busycnt", count("busy", 0, 5), 0);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have no parameters; the block size is fixed at 8 words of 16 bits (16 bytes), and addresses are 16 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- miss_detected  input  1  a cache miss is pending (the cache Miss output, qualified by the requester).
- miss_address  input  16  byte address that missed.
- memory_data_valid  input  1  memory returns one word this cycle.
- mem_read_en  output  1  request one word read from memory this cycle.
- memory_address  output  16  byte address of the current memory read request.
- fsm_busy  output  1  a fill is in progress; the requester stalls.
- write_data_array  output  1  write memory_data into the cache data array at word_num this cycle.
- word_num  output  3  word index within the block for the current data-array write.
- write_tag_array  output  1  write the valid+tag for the filling block this cycle.
REQ-003 The memory data word SHALL be routed by the top level directly to the cache Data_In and SHALL NOT pass through this block.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and FILL.
REQ-005 In IDLE, miss_detected=1 at a clock edge SHALL cause the following:
- latch base = {miss_address[15:4], 4'h0};
- clear issue_cnt and recv_cnt (4-bit each);
- enter FILL on that edge.
REQ-006 In IDLE, memory_data_valid SHALL be ignored, and all outputs SHALL be 0 (memory_address = 16'h0000, word_num = 3'b000).
REQ-007 fsm_busy SHALL be 1 exactly while the state is FILL, including the cycle in which write_tag_array is asserted.
REQ-008 In FILL, mem_read_en SHALL equal 1 while issue_cnt < 8, giving one request per cycle for 8 consecutive cycles with no gaps.
REQ-009 When mem_read_en=1, memory_address SHALL equal {base[15:4], issue_cnt[2:0], 1'b0}; otherwise memory_address SHALL be 16'h0000.
REQ-010 issue_cnt SHALL increment on each edge where mem_read_en=1 and SHALL stop at 8.
REQ-011 In FILL, write_data_array SHALL equal memory_data_valid (combinational), and word_num SHALL equal recv_cnt[2:0].
REQ-012 recv_cnt SHALL increment on each edge where memory_data_valid=1 in FILL.
REQ-013 When memory_data_valid=1 and recv_cnt=7 in FILL, the block SHALL take these actions:
- assert write_tag_array for that cycle only, concurrent with the final data write;
- return to IDLE on that edge.
REQ-014 Return data SHALL be accepted in any cycle of FILL, including cycles in which requests are still issuing (overlap of issue and return is normal); the number of returns SHALL never be required to equal the number of issues at any intermediate point.
REQ-015 miss_detected SHALL be ignored while in FILL; a new miss SHALL be accepted only from IDLE, at the earliest on the edge after the tag write.
REQ-016 base SHALL be held constant for the whole fill even if miss_address changes.
REQ-017 Memory SHALL return exactly one valid word per issued request, in order; memory_data_valid in IDLE SHALL have no effect.
REQ-018 write_data_array and write_tag_array SHALL never be asserted outside FILL.

Reset
REQ-019 rst=0 at a clock edge SHALL force the following, overriding all other inputs:
- state = IDLE;
- issue_cnt = recv_cnt = 0;
- base = 16'h0000.
REQ-020 After reset, all outputs SHALL be 0.
REQ-021 A reset asserted mid-fill SHALL abort the fill with no tag write; in-flight memory returns arriving after reset SHALL be ignored.
REQ-022 State SHALL NOT change asynchronously; rst is sampled only on the clk rising edge.

Verification
REQ-023 Basic fill, memory latency 4: miss_detected pulse with miss_address=16'h3A56 at edge 0, expecting:
- mem_read_en during cycles 1-8, with memory_address 16'h3A50, 3A52, ... 3A5E;
- write_data_array during cycles 5-12, with word_num 0..7;
- write_tag_array in cycle 12 only;
- fsm_busy during cycles 1-12;
- IDLE in cycle 13.
REQ-024 Latency 1 (overlapped issue/return): miss at 16'h0008 -> 8 data writes with word_num 0..7 in issue order, a tag write with the 8th, and no extra requests after the 8th.
REQ-025 Gappy returns: valids in cycles 5, 7, 9, ... (alternating) -> word_num advances only on valid cycles; the tag is written on the 8th valid; fsm_busy is held throughout.
REQ-026 Miss during fill: miss_detected held high with a changing miss_address for the whole fill -> base unchanged; a second fill of the new address starts on the edge after write_tag_array.
REQ-027 Reset mid-fill: rst=0 at cycle 6 of the REQ-023 case -> from cycle 7 all outputs are 0, with no write_tag_array; remaining valids are ignored; the next miss fills normally from word 0.
REQ-028 Stray data: memory_data_valid pulsed in IDLE -> no write_data_array, no state change.
